// File: rtl/tage_hist_fold_pkg.sv
// Shared constants for the TAGE folded-history block: table geometry and FSM encoding.
// Table history lengths are fixed; only the index/tag widths are parameterisable at the top.
package tage_hist_fold_pkg;

  localparam int unsigned NumTables = 4;
  localparam int unsigned L0        = 5;
  localparam int unsigned L1        = 15;
  localparam int unsigned L2        = 44;
  localparam int unsigned L3        = 131;
  localparam int unsigned IdxW      = 10;
  localparam int unsigned TagW      = 8;

  typedef enum logic [0:0] {
    StReady,
    StRebuild
  } state_e;

  function automatic int unsigned hist_len(input int unsigned t);
    case (t)
      0:       return L0;
      1:       return L1;
      2:       return L2;
      default: return L3;
    endcase
  endfunction

endpackage

// File: rtl/tage_hist_fold_if.sv
// Lookup/history bus of the folded-history block.
// The master drives history and lookup requests; the slave returns indices and tags.
interface tage_hist_fold_if #(
  parameter int unsigned GlobLen = 131,
  parameter int unsigned PLen    = 16,
  parameter int unsigned PcLen   = 32,
  parameter int unsigned IdxW    = 10,
  parameter int unsigned TagW    = 8
);

  logic [GlobLen-1:0] ghist;
  logic [PLen-1:0]    phist;
  logic               hist_shift_valid;
  logic               new_bit;
  logic               rebuild_req;
  logic               lookup_valid;
  logic               lookup_ready;
  logic [PcLen-1:0]   lookup_pc;
  logic               idx_valid;
  logic [4*IdxW-1:0]  index;
  logic [4*TagW-1:0]  tag;
  logic               busy;

  modport master (
    output ghist, phist, hist_shift_valid, new_bit, rebuild_req, lookup_valid, lookup_pc,
    input  lookup_ready, idx_valid, index, tag, busy
  );

  modport slave (
    input  ghist, phist, hist_shift_valid, new_bit, rebuild_req, lookup_valid, lookup_pc,
    output lookup_ready, idx_valid, index, tag, busy
  );

endinterface

// File: rtl/hist_fold_reg.sv
// One folded-history register of width W over the newest L history bits.
// Supports incremental shift, one serial rebuild step (newest-last), and clear.
module hist_fold_reg #(
  parameter int unsigned L  = 5,
  parameter int unsigned W  = 10,
  parameter int unsigned KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  input  logic [KW-1:0] k,
  input  logic          step_bit,
  input  logic          shift,
  input  logic          new_bit,
  input  logic          old_bit,
  output logic [W-1:0]  fold
);

  logic [W-1:0] fold_q, fold_d, rot;

  always_comb begin
    rot    = {fold_q[W-2:0], fold_q[W-1]};
    fold_d = fold_q;
    if (clear) begin
      fold_d = '0;
    end else if (step) begin
      // Bits older than this table's window are skipped during the serial walk.
      if (32'(k) < L) fold_d = rot ^ W'(step_bit);
    end else if (shift) begin
      fold_d          = rot;
      fold_d[0]       = fold_d[0] ^ new_bit;
      fold_d[L % W]   = fold_d[L % W] ^ old_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fold_q <= '0;
    else        fold_q <= fold_d;
  end

  assign fold = fold_q;

endmodule

// File: rtl/tage_hist_fold.sv
// TAGE folded global-history registers for four tables plus registered index/tag lookup.
// A rebuild walks ghist oldest-to-newest, one bit per cycle, for GlobLen cycles.
module tage_hist_fold #(
  parameter int unsigned GlobLen = 131,
  parameter int unsigned PLen    = 16,
  parameter int unsigned pc_len  = 32,
  parameter int unsigned IdxW    = tage_hist_fold_pkg::IdxW,
  parameter int unsigned TagW    = tage_hist_fold_pkg::TagW
) (
  input logic             CLK,
  input logic             reset,
  tage_hist_fold_if.slave bus
);
  import tage_hist_fold_pkg::*;

  localparam int unsigned KW = $clog2(GlobLen);
  localparam logic [KW-1:0] KLoad = KW'(GlobLen - 1);

  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic fold_clear, fold_step, fold_shift, accept, restart, step_bit;

  logic [IdxW-1:0]   fi  [NumTables];
  logic [TagW-1:0]   ft0 [NumTables];
  logic [TagW-2:0]   ft1 [NumTables];
  logic [4*IdxW-1:0] index_q, index_d;
  logic [4*TagW-1:0] tag_q, tag_d;
  logic              idx_valid_q;

  assign restart  = bus.hist_shift_valid || bus.rebuild_req;
  assign step_bit = bus.ghist[k_q];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StReady;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StReady: begin
        if (bus.rebuild_req) begin
          state_d = StRebuild;
          k_d     = KLoad;
        end
      end
      StRebuild: begin
        if (restart)          k_d     = KLoad;
        else if (k_q == '0)   state_d = StReady;
        else                  k_d     = k_q - 1'b1;
      end
    endcase
  end

  always_comb begin
    fold_clear       = 1'b0;
    fold_step        = 1'b0;
    fold_shift       = 1'b0;
    accept           = 1'b0;
    bus.lookup_ready = 1'b0;
    bus.busy         = 1'b0;
    unique case (state_q)
      StReady: begin
        bus.lookup_ready = 1'b1;
        accept           = bus.lookup_valid;
        fold_clear       = bus.rebuild_req;
        fold_shift       = bus.hist_shift_valid;
      end
      StRebuild: begin
        bus.busy   = 1'b1;
        fold_clear = restart;
        fold_step  = !restart;
      end
    endcase
  end

  for (genvar t = 0; t < NumTables; t++) begin : g_tab
    localparam int unsigned Len = hist_len(t);

    hist_fold_reg #(.L(Len), .W(IdxW), .KW(KW)) u_fi (
      .clk(CLK), .rst_n(reset), .clear(fold_clear), .step(fold_step), .k(k_q),
      .step_bit(step_bit), .shift(fold_shift), .new_bit(bus.new_bit),
      .old_bit(bus.ghist[Len-1]), .fold(fi[t])
    );

    hist_fold_reg #(.L(Len), .W(TagW), .KW(KW)) u_ft0 (
      .clk(CLK), .rst_n(reset), .clear(fold_clear), .step(fold_step), .k(k_q),
      .step_bit(step_bit), .shift(fold_shift), .new_bit(bus.new_bit),
      .old_bit(bus.ghist[Len-1]), .fold(ft0[t])
    );

    hist_fold_reg #(.L(Len), .W(TagW-1), .KW(KW)) u_ft1 (
      .clk(CLK), .rst_n(reset), .clear(fold_clear), .step(fold_step), .k(k_q),
      .step_bit(step_bit), .shift(fold_shift), .new_bit(bus.new_bit),
      .old_bit(bus.ghist[Len-1]), .fold(ft1[t])
    );
  end

  // Folds are read before this edge's update, so a coincident shift is not yet visible.
  always_comb begin
    index_d = index_q;
    tag_d   = tag_q;
    if (accept) begin
      for (int t = 0; t < NumTables; t++) begin
        index_d[t*IdxW +: IdxW] = bus.lookup_pc[2 +: IdxW] ^ bus.lookup_pc[2+IdxW +: IdxW]
                                ^ fi[t] ^ bus.phist[IdxW-1:0];
        tag_d[t*TagW +: TagW]   = bus.lookup_pc[2 +: TagW] ^ ft0[t] ^ {ft1[t], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idx_valid_q <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
    end else begin
      idx_valid_q <= accept;
      index_q     <= index_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.idx_valid = idx_valid_q;
  assign bus.index     = index_q;
  assign bus.tag       = tag_q;

  logic unused_bits;
  assign unused_bits = ^{bus.phist[PLen-1:IdxW], bus.lookup_pc[pc_len-1:2+2*IdxW],
                         bus.lookup_pc[1:0]};

endmodule

// File: tb/tb_tage_hist_fold.sv
// Directed bench for tage_hist_fold: reset, lookup math, incremental folds, rebuild and restart.
// Expected folds come from a direct bit-by-bit fold of the bench's own history copy.
module tb_tage_hist_fold;

  localparam int unsigned GlobLen = 131;
  localparam int unsigned PLen    = 16;
  localparam int unsigned PcLen   = 32;
  localparam int unsigned IdxW    = 10;
  localparam int unsigned TagW    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tage_hist_fold_if #(
    .GlobLen(GlobLen), .PLen(PLen), .PcLen(PcLen), .IdxW(IdxW), .TagW(TagW)
  ) bus ();

  tage_hist_fold #(
    .GlobLen(GlobLen), .PLen(PLen), .pc_len(PcLen), .IdxW(IdxW), .TagW(TagW)
  ) dut (
    .CLK(clk), .reset(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [GlobLen-1:0] gh;

  function automatic int hl(input int t);
    case (t)
      0:       return 5;
      1:       return 15;
      2:       return 44;
      default: return 131;
    endcase
  endfunction

  // History bit i lands at fold position i mod w.
  function automatic logic [15:0] fold_ref(input logic [GlobLen-1:0] h, input int l, input int w);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < l; i++) f[i % w] = f[i % w] ^ h[i];
    return f;
  endfunction

  function automatic logic [39:0] exp_index(input logic [31:0] pc, input logic [15:0] ph,
                                            input logic [GlobLen-1:0] h);
    logic [39:0] r;
    logic [15:0] f;
    for (int t = 0; t < 4; t++) begin
      f = fold_ref(h, hl(t), 10);
      r[t*10 +: 10] = pc[11:2] ^ pc[21:12] ^ f[9:0] ^ ph[9:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_tag(input logic [31:0] pc, input logic [GlobLen-1:0] h);
    logic [31:0] r;
    logic [15:0] f0, f1;
    for (int t = 0; t < 4; t++) begin
      f0 = fold_ref(h, hl(t), 8);
      f1 = fold_ref(h, hl(t), 7);
      r[t*8 +: 8] = pc[9:2] ^ f0[7:0] ^ {f1[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input logic b);
    bus.hist_shift_valid = 1'b1;
    bus.new_bit          = b;
    tick();
    bus.hist_shift_valid = 1'b0;
    gh        = {gh[GlobLen-2:0], b};
    bus.ghist = gh;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    tick();
    bus.lookup_valid = 1'b0;
  endtask

  // Starts a rebuild and counts busy cycles; optionally shifts during busy cycle inject_at.
  task automatic run_rebuild(input int inject_at, output int n, output logic ready_seen);
    bit shifting;
    logic b;
    n          = 0;
    ready_seen = 1'b0;
    shifting   = 0;
    bus.rebuild_req = 1'b1;
    tick();
    bus.rebuild_req = 1'b0;
    while (bus.busy && n < 1000) begin
      n++;
      if (bus.lookup_ready) ready_seen = 1'b1;
      if (n == inject_at) begin
        b = 1'($urandom);
        bus.hist_shift_valid = 1'b1;
        bus.new_bit          = b;
        shifting             = 1;
      end
      tick();
      if (shifting) begin
        shifting             = 0;
        bus.hist_shift_valid = 1'b0;
        gh        = {gh[GlobLen-2:0], b};
        bus.ghist = gh;
      end
    end
  endtask

  logic [31:0] pc;
  logic [39:0] rec_idx;
  logic [31:0] rec_tag;
  logic [39:0] pre_idx;
  logic [31:0] pre_tag;
  logic [GlobLen-1:0] gh_pre;
  int n;
  logic ready_seen;
  logic busy_seen;

  initial begin
    rst_n                = 1'b0;
    gh                   = '0;
    bus.ghist            = '0;
    bus.phist            = '0;
    bus.hist_shift_valid = 1'b0;
    bus.new_bit          = 1'b0;
    bus.rebuild_req      = 1'b0;
    bus.lookup_valid     = 1'b0;
    bus.lookup_pc        = '0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.lookup_ready), 64'd1);
    check("rst_idx_valid", 64'(bus.idx_valid), 64'd0);
    check("rst_index", 64'(bus.index), 64'd0);
    check("rst_tag", 64'(bus.tag), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Zero folds: index/tag depend only on the PC.
    do_lookup(32'h0000_0ABC);
    check("pc_abc_valid", 64'(bus.idx_valid), 64'd1);
    check("pc_abc_index", 64'(bus.index), 64'({4{10'h2AF}}));
    check("pc_abc_tag", 64'(bus.tag), 64'({4{8'hAF}}));
    tick();
    check("idx_valid_pulse", 64'(bus.idx_valid), 64'd0);
    check("index_hold", 64'(bus.index), 64'({4{10'h2AF}}));

    // A single 1 shifted six deep: out of table 0's window, at bit 5 elsewhere.
    do_shift(1'b1);
    for (int i = 0; i < 5; i++) do_shift(1'b0);
    do_lookup(32'h0);
    check("six_shift_index", 64'(bus.index), 64'({10'h020, 10'h020, 10'h020, 10'h000}));
    check("six_shift_tag", 64'(bus.tag), 64'({8'h60, 8'h60, 8'h60, 8'h00}));

    // Random history, then a full rebuild must reproduce the same lookup.
    for (int i = 0; i < 200; i++) do_shift(1'($urandom));
    bus.phist = 16'($urandom);
    pc        = $urandom;
    do_lookup(pc);
    rec_idx = bus.index;
    rec_tag = bus.tag;
    check("rand_index", 64'(rec_idx), 64'(exp_index(pc, bus.phist, gh)));
    check("rand_tag", 64'(rec_tag), 64'(exp_tag(pc, gh)));
    run_rebuild(0, n, ready_seen);
    check("rebuild_cycles", 64'(n), 64'd131);
    check("rebuild_ready_low", 64'(ready_seen), 64'd0);
    do_lookup(pc);
    check("rebuild_index", 64'(bus.index), 64'(rec_idx));
    check("rebuild_tag", 64'(bus.tag), 64'(rec_tag));

    // Shift during the 50th busy cycle restarts the walk over the updated history.
    run_rebuild(50, n, ready_seen);
    check("restart_cycles", 64'(n), 64'd181);
    pc = $urandom;
    do_lookup(pc);
    check("restart_index", 64'(bus.index), 64'(exp_index(pc, bus.phist, gh)));
    check("restart_tag", 64'(bus.tag), 64'(exp_tag(pc, gh)));

    // Coincident lookup and shift see pre-shift folds; the next lookup sees post-shift.
    pc     = $urandom;
    gh_pre = gh;
    bus.lookup_valid     = 1'b1;
    bus.lookup_pc        = pc;
    bus.hist_shift_valid = 1'b1;
    bus.new_bit          = ~gh[4];
    tick();
    bus.lookup_valid     = 1'b0;
    bus.hist_shift_valid = 1'b0;
    gh        = {gh[GlobLen-2:0], bus.new_bit};
    bus.ghist = gh;
    pre_idx = exp_index(pc, bus.phist, gh_pre);
    pre_tag = exp_tag(pc, gh_pre);
    check("coinc_index", 64'(bus.index), 64'(pre_idx));
    check("coinc_tag", 64'(bus.tag), 64'(pre_tag));
    do_lookup(pc);
    check("post_shift_index", 64'(bus.index), 64'(exp_index(pc, bus.phist, gh)));
    check("post_shift_tag", 64'(bus.tag), 64'(exp_tag(pc, gh)));

    // Asynchronous reset in the middle of a rebuild.
    bus.rebuild_req = 1'b1;
    tick();
    bus.rebuild_req = 1'b0;
    repeat (60) tick();
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_ready", 64'(bus.lookup_ready), 64'd1);
    check("async_idx_valid", 64'(bus.idx_valid), 64'd0);
    check("async_index", 64'(bus.index), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.busy) busy_seen = 1'b1;
    end
    check("no_resume", 64'(busy_seen), 64'd0);
    bus.phist = '0;
    do_lookup(32'h0);
    check("folds_cleared_index", 64'(bus.index), 64'd0);
    check("folds_cleared_tag", 64'(bus.tag), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
